// File: rtl/dual_port_ram_if.sv
// ============================================================================
// Module      : dual_port_ram_if
// Description : Bus bundle for the two-port RAM. Both access ports are
//               grouped here with the status flags.
//               master : drives port strobes, address and write data
//               slave  : the RAM; returns read data, busy and collision
//   a_enable/b_enable   port access strobe
//   a_WE/b_WE           write qualifier (only with enable)
//   a_address/b_address bus address (upper bits mirror)
//   a_wdata/b_wdata     write data
//   a_rdata/b_rdata     registered read data
//   busy                clear sequence running, ports ignored
//   collision           both ports wrote one physical word last cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_port_ram_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     a_enable;
  logic                     a_WE;
  logic [ADDRESS_WIDTH-1:0] a_address;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic [DATA_WIDTH-1:0]    a_rdata;
  logic                     b_enable;
  logic                     b_WE;
  logic [ADDRESS_WIDTH-1:0] b_address;
  logic [DATA_WIDTH-1:0]    b_wdata;
  logic [DATA_WIDTH-1:0]    b_rdata;
  logic                     busy;
  logic                     collision;

  modport master (
    output a_enable, a_WE, a_address, a_wdata,
    output b_enable, b_WE, b_address, b_wdata,
    input  a_rdata, b_rdata, busy, collision
  );

  modport slave (
    input  a_enable, a_WE, a_address, a_wdata,
    input  b_enable, b_WE, b_address, b_wdata,
    output a_rdata, b_rdata, busy, collision
  );
endinterface

`default_nettype wire

// File: rtl/dual_port_ram.sv
// ============================================================================
// Module      : dual_port_ram
// Description : Two-port synchronous RAM with address mirroring, selectable
//               same-port read-during-write mode and a zero-fill sequencer
//               that runs after reset release.
//   clk      in   single clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of dual_port_ram_if (ports A/B, busy, collision)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_port_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DEPTH_BITS     = 11,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  dual_port_ram_if.slave    bus
);

  localparam int DEPTH = 2 ** DEPTH_BITS;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  state_q, state_d;
  logic [DEPTH_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0]   b_rdata_q, b_rdata_d;
  logic                    collision_q, collision_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    ready;
  logic [DEPTH_BITS-1:0]   a_idx, b_idx;
  logic                    a_wr, b_wr, same_idx;
  logic                    pa_we, pb_we;
  logic [DEPTH_BITS-1:0]   pa_addr;
  logic [DATA_WIDTH-1:0]   pa_data;
  logic                    unused_addr_bits;

  // Upper address bits are discarded: the array repeats across the bus space.
  assign a_idx            = bus.a_address[DEPTH_BITS-1:0];
  assign b_idx            = bus.b_address[DEPTH_BITS-1:0];
  assign unused_addr_bits = ^{bus.a_address, bus.b_address};

  assign ready    = (state_q == ST_READY);
  assign a_wr     = ready && bus.a_enable && bus.a_WE;
  assign b_wr     = ready && bus.b_enable && bus.b_WE;
  assign same_idx = (a_idx == b_idx);

  // The clear sequencer borrows port A's write path so the array keeps
  // exactly two write ports; the ports are idle while clearing.
  assign pa_we   = a_wr || (state_q == ST_CLEAR);
  assign pa_addr = ready ? a_idx : clr_cnt_q;
  assign pa_data = ready ? bus.a_wdata : '0;
  // Port A wins a same-word write, so B's write is suppressed then.
  assign pb_we   = b_wr && !(a_wr && same_idx);

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    collision_d = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {DEPTH_BITS{1'b1}}) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // Array reads below see pre-edge contents, giving old data for
        // cross-port reads and for read-first same-port reads.
        if (bus.a_enable) begin
          a_rdata_d = (READ_MODE != 0 && bus.a_WE) ? bus.a_wdata : mem_q[a_idx];
        end
        if (bus.b_enable) begin
          b_rdata_d = (READ_MODE != 0 && bus.b_WE) ? bus.b_wdata : mem_q[b_idx];
        end
        collision_d = a_wr && b_wr && same_idx;
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      collision_q <= collision_d;
    end
  end

  // Storage array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (pa_we) begin
      mem_q[pa_addr] <= pa_data;
    end
    if (pb_we) begin
      mem_q[b_idx] <= bus.b_wdata;
    end
  end

  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.collision = collision_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram.sv
// ============================================================================
// Module      : tb_dual_port_ram
// Description : Directed bench for dual_port_ram. dut0 uses read-first with
//               clear-on-reset; dut1 uses write-first without clearing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_port_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n;
  logic rst1_n;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc;

  dual_port_ram_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(16)) ifa ();
  dual_port_ram_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(16)) ifb ();

  dual_port_ram #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(16), .DEPTH_BITS(11),
    .READ_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(ifa)
  );

  dual_port_ram #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(16), .DEPTH_BITS(11),
    .READ_MODE(1), .CLEAR_ON_RESET(0)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .bus(ifb)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a0(input logic en, input logic we, input logic [15:0] addr, input logic [7:0] d);
    ifa.a_enable = en; ifa.a_WE = we; ifa.a_address = addr; ifa.a_wdata = d;
  endtask

  task automatic b0(input logic en, input logic we, input logic [15:0] addr, input logic [7:0] d);
    ifa.b_enable = en; ifa.b_WE = we; ifa.b_address = addr; ifa.b_wdata = d;
  endtask

  task automatic a1(input logic en, input logic we, input logic [15:0] addr, input logic [7:0] d);
    ifb.a_enable = en; ifb.a_WE = we; ifb.a_address = addr; ifb.a_wdata = d;
  endtask

  task automatic b1(input logic en, input logic we, input logic [15:0] addr, input logic [7:0] d);
    ifb.b_enable = en; ifb.b_WE = we; ifb.b_address = addr; ifb.b_wdata = d;
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    a0(1'b0, 1'b0, 16'h0, 8'h0); b0(1'b0, 1'b0, 16'h0, 8'h0);
    a1(1'b0, 1'b0, 16'h0, 8'h0); b1(1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    tick();

    // Reset state
    check("rst_busy0",  16'(ifa.busy),      16'h1);
    check("rst_a0",     16'(ifa.a_rdata),   16'h0);
    check("rst_b0",     16'(ifa.b_rdata),   16'h0);
    check("rst_coll0",  16'(ifa.collision), 16'h0);
    check("rst_busy1",  16'(ifb.busy),      16'h0);

    // dut1: no clear, write-first; first edge after release is usable
    rst1_n = 1'b1;
    a1(1'b1, 1'b1, 16'h0040, 8'h11);
    tick();
    check("wf_first_wr_a", 16'(ifb.a_rdata), 16'h11);
    a1(1'b1, 1'b1, 16'h0040, 8'h22); b1(1'b1, 1'b0, 16'h0040, 8'h00);
    tick();
    check("wf_rdw_a", 16'(ifb.a_rdata), 16'h22);
    check("wf_rdw_b", 16'(ifb.b_rdata), 16'h11);
    a1(1'b1, 1'b1, 16'h0100, 8'h33); b1(1'b1, 1'b1, 16'h0100, 8'h44);
    tick();
    check("wf_coll_a",    16'(ifb.a_rdata),   16'h33);
    check("wf_coll_b",    16'(ifb.b_rdata),   16'h44);
    check("wf_coll_flag", 16'(ifb.collision), 16'h1);
    a1(1'b0, 1'b0, 16'h0000, 8'h00); b1(1'b1, 1'b0, 16'h0100, 8'h00);
    tick();
    check("wf_coll_store", 16'(ifb.b_rdata),   16'h33);
    check("wf_coll_clr",   16'(ifb.collision), 16'h0);
    b1(1'b0, 1'b0, 16'h0000, 8'h00);

    // dut0: clear sequence; a write injected mid-clear must be dropped
    rst0_n = 1'b1;
    cyc = 0;
    while (ifa.busy && cyc < 3000) begin
      if (cyc == 100) a0(1'b1, 1'b1, 16'h0005, 8'hAA);
      else            a0(1'b0, 1'b0, 16'h0000, 8'h00);
      tick();
      cyc++;
    end
    a0(1'b0, 1'b0, 16'h0000, 8'h00);
    check("clear_len",    16'(cyc),         16'd2048);
    check("clear_a_hold", 16'(ifa.a_rdata), 16'h0);

    a0(1'b1, 1'b0, 16'h0000, 8'h00); b0(1'b1, 1'b0, 16'h03FF, 8'h00);
    tick();
    check("clr_rd_0000", 16'(ifa.a_rdata), 16'h0);
    check("clr_rd_03FF", 16'(ifa.b_rdata), 16'h0);
    a0(1'b1, 1'b0, 16'h07FF, 8'h00); b0(1'b1, 1'b0, 16'h0005, 8'h00);
    tick();
    check("clr_rd_07FF",  16'(ifa.a_rdata), 16'h0);
    check("clr_drop_wr",  16'(ifa.b_rdata), 16'h0);

    // Mirroring
    a0(1'b1, 1'b1, 16'h0012, 8'h5C); b0(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    a0(1'b0, 1'b0, 16'h0000, 8'h00); b0(1'b1, 1'b0, 16'h0812, 8'h00);
    tick();
    check("mirror_0812", 16'(ifa.b_rdata), 16'h5C);
    b0(1'b1, 1'b0, 16'h1012, 8'h00);
    tick();
    check("mirror_1012", 16'(ifa.b_rdata), 16'h5C);
    b0(1'b1, 1'b0, 16'h1812, 8'h00);
    tick();
    check("mirror_1812", 16'(ifa.b_rdata), 16'h5C);

    // Read-during-write, read-first
    a0(1'b1, 1'b1, 16'h0040, 8'h11); b0(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    a0(1'b1, 1'b1, 16'h0040, 8'h22); b0(1'b1, 1'b0, 16'h0040, 8'h00);
    tick();
    check("rf_rdw_a", 16'(ifa.a_rdata), 16'h11);
    check("rf_rdw_b", 16'(ifa.b_rdata), 16'h11);
    a0(1'b1, 1'b0, 16'h0040, 8'h00); b0(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    check("rf_rdw_new", 16'(ifa.a_rdata), 16'h22);

    // Write collision, two consecutive colliding cycles
    a0(1'b1, 1'b1, 16'h0100, 8'h33); b0(1'b1, 1'b1, 16'h0100, 8'h44);
    tick();
    check("coll_flag1", 16'(ifa.collision), 16'h1);
    check("coll_a_old", 16'(ifa.a_rdata),   16'h0);
    check("coll_b_old", 16'(ifa.b_rdata),   16'h0);
    a0(1'b1, 1'b1, 16'h0100, 8'h33); b0(1'b1, 1'b1, 16'h0100, 8'h66);
    tick();
    check("coll_flag2", 16'(ifa.collision), 16'h1);
    check("coll_a_won", 16'(ifa.a_rdata),   16'h33);
    check("coll_b_won", 16'(ifa.b_rdata),   16'h33);
    a0(1'b1, 1'b1, 16'h0102, 8'h01); b0(1'b1, 1'b1, 16'h0103, 8'h02);
    tick();
    check("nocoll_diff", 16'(ifa.collision), 16'h0);
    a0(1'b1, 1'b0, 16'h0100, 8'h00); b0(1'b1, 1'b0, 16'h0103, 8'h00);
    tick();
    check("coll_store_a", 16'(ifa.a_rdata),   16'h33);
    check("diff_store_b", 16'(ifa.b_rdata),   16'h02);
    check("coll_drop",    16'(ifa.collision), 16'h0);

    // Hold while disabled
    a0(1'b1, 1'b1, 16'h0200, 8'h7E); b0(1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    a0(1'b1, 1'b0, 16'h0200, 8'h00);
    tick();
    check("hold_rd", 16'(ifa.a_rdata), 16'h7E);
    for (int i = 0; i < 5; i++) begin
      a0(1'b0, 1'b0, 16'h0012 + 16'(i), 8'h00);
      if (i == 4) b0(1'b1, 1'b0, 16'h0012, 8'h00);
      tick();
      check("hold_a", 16'(ifa.a_rdata), 16'h7E);
    end
    check("hold_b_rd", 16'(ifa.b_rdata), 16'h5C);
    b0(1'b0, 1'b0, 16'h0000, 8'h00);

    // Asynchronous reset mid-cycle clears outputs at once
    #2;
    rst0_n = 1'b0;
    #1;
    check("arst_a",    16'(ifa.a_rdata), 16'h0);
    check("arst_b",    16'(ifa.b_rdata), 16'h0);
    check("arst_busy", 16'(ifa.busy),    16'h1);
    tick();
    rst0_n = 1'b1;
    repeat (1000) tick();
    check("mid_busy", 16'(ifa.busy), 16'h1);

    // Reset at counter 1000 restarts the full clear
    #2;
    rst0_n = 1'b0;
    #1;
    check("mid_rst_busy", 16'(ifa.busy),    16'h1);
    check("mid_rst_a",    16'(ifa.a_rdata), 16'h0);
    tick();
    rst0_n = 1'b1;
    cyc = 0;
    while (ifa.busy && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("reclear_len", 16'(cyc), 16'd2048);
    a0(1'b1, 1'b0, 16'h0200, 8'h00); b0(1'b1, 1'b0, 16'h0100, 8'h00);
    tick();
    check("reclear_a", 16'(ifa.a_rdata), 16'h0);
    check("reclear_b", 16'(ifa.b_rdata), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
